freq_meter_top: RTL and testbench

- FPGA top level that bridges UART to SPI for the board's serial flash and mirrors traffic on LEDs and a 4-digit 7-segment display.
- Each byte received on the UART is sent as one SPI byte to the flash. The byte clocked back on MISO is returned over the UART TX.
- Single clock domain. Reset is synchronous and active-high.

---
 rtl/freq_meter_pkg.sv | 37 +++
 rtl/uart_8n1.sv | 112 +++++++++++
 rtl/freq_meter_top.sv | 166 ++++++++++++++++
 tb/tb_freq_meter_top.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types, constants and helpers for the UART-to-SPI flash bridge.
package freq_meter_pkg;

  // Bridge sequencing: wait for a command byte, run one SPI byte, send the reply.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPI  = 2'd1,
    TX   = 2'd2
  } bridge_state_t;

  // UART receiver states; UNARMED means the line has not been seen high yet.
  typedef enum logic [2:0] {
    RX_UNARMED = 3'd0,
    RX_ARMED   = 3'd1,
    RX_START   = 3'd2,
    RX_DATA    = 3'd3,
    RX_STOP    = 3'd4
  } rx_state_t;

  // Debug view of both state machines.
  typedef struct packed {
    rx_state_t     rx;
    bridge_state_t bridge;
  } dbg_t;

  // Active-low {dp,g,f,e,d,c,b,a} patterns, index = hex digit value.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Clocks per UART bit, rounded to nearest.
  function automatic int bit_clks(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART: receiver with 2-FF synchronizer, start re-check and stop-bit
// framing check, plus a transmitter with a busy flag.
//
// Handshake: o_rx_valid is a single-cycle pulse with o_rx_data stable in the
// same cycle; there is no backpressure, a consumer that is not ready simply
// ignores it. i_tx_start is taken only in a cycle where o_tx_busy is low, and
// o_tx_busy rises on the following clock and stays high for the whole frame.
module uart_8n1
  import freq_meter_pkg::*;
#(
  parameter int BIT_CLKS = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx,
  output logic       o_tx_busy,
  output rx_state_t  o_rx_state
);

  localparam int CW = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);

  logic          r_rx_s1, r_rx_s2;
  rx_state_t     r_rx_state, w_rx_next;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_valid;
  logic          w_rx_tick, w_rx_half;

  logic [9:0]    r_tx_shift;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bits;
  logic          r_tx_busy;

  assign w_rx_tick  = (r_rx_cnt == BIT_LAST);
  assign w_rx_half  = (r_rx_cnt == HALF_LAST);
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_shift;
  assign o_rx_state = r_rx_state;
  assign o_tx       = r_tx_shift[0];
  assign o_tx_busy  = r_tx_busy;

  // RX next state: arm on high line, confirm start mid-bit, check stop bit.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_UNARMED: if (r_rx_s2) w_rx_next = RX_ARMED;
      RX_ARMED:   if (!r_rx_s2) w_rx_next = RX_START;
      RX_START:   if (w_rx_half) w_rx_next = r_rx_s2 ? RX_ARMED : RX_DATA;
      RX_DATA:    if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:    if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_ARMED : RX_UNARMED;
      default:    w_rx_next = RX_UNARMED;
    endcase
  end

  // RX state register, synchronizer, bit timer and data shifter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_s1    <= 1'b0;
      r_rx_s2    <= 1'b0;
      r_rx_state <= RX_UNARMED;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_s1    <= i_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
      r_rx_valid <= (r_rx_state == RX_STOP) && w_rx_tick && r_rx_s2;
      if ((w_rx_next != r_rx_state) || w_rx_tick) r_rx_cnt <= '0;
      else r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state == RX_START) r_rx_bit <= '0;
      if ((r_rx_state == RX_DATA) && w_rx_tick) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
    end
  end

  // TX: load start/data/stop into a shifter that idles all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_busy  <= 1'b0;
    end else if (!r_tx_busy) begin
      if (i_tx_start) begin
        r_tx_shift <= {1'b1, i_tx_data, 1'b0};
        r_tx_cnt   <= '0;
        r_tx_bits  <= '0;
        r_tx_busy  <= 1'b1;
      end
    end else if (r_tx_cnt == BIT_LAST) begin
      r_tx_cnt   <= '0;
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      if (r_tx_bits == 4'd9) r_tx_busy <= 1'b0;
      else r_tx_bits <= r_tx_bits + 1'b1;
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/freq_meter_top.sv
// Board top: each UART byte becomes one SPI flash byte, the MISO byte is sent
// back over UART, and {cmd,resp} is shown on a scanned 4-digit display.
module freq_meter_top
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int SPI_DIV  = 4,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx,
  output logic       tx,
  inout  wire  [3:0] leds_io,
  output logic       flash_CS,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic [7:0] segments,
  output logic [3:0] seg_selectors,
  output dbg_t       o_dbg
);

  localparam int BIT_CLKS = bit_clks(CLK_HZ, BAUD);
  localparam int DW = $clog2(SPI_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] SPI_LAST  = DW'(SPI_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic          w_rx_valid, w_tx_busy;
  logic [7:0]    w_rx_data;
  rx_state_t     w_rx_state;
  bridge_state_t r_state, w_next;

  logic [7:0]    r_cmd, r_resp, r_spi_shift, r_spi_cap;
  logic [3:0]    r_leds;
  logic          r_cs, r_sck, r_mosi, r_tx_start;
  logic [DW-1:0] r_spi_cnt;
  logic [4:0]    r_spi_half;
  logic          w_spi_tick, w_spi_done;

  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_digit;
  logic [3:0]    w_nibble;
  logic [7:0]    r_seg;
  logic [3:0]    r_sel;

  uart_8n1 #(.BIT_CLKS(BIT_CLKS)) u_uart (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_rx       (rx),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data),
    .i_tx_start (r_tx_start),
    .i_tx_data  (r_resp),
    .o_tx       (tx),
    .o_tx_busy  (w_tx_busy),
    .o_rx_state (w_rx_state)
  );

  assign leds_io       = r_leds;
  assign flash_CS      = r_cs;
  assign sck_o         = r_sck;
  assign mosi_o        = r_mosi;
  assign segments      = r_seg;
  assign seg_selectors = r_sel;
  assign o_dbg         = {w_rx_state, r_state};

  // The SPI byte is 18 half-periods: setup, 8 x (high, low), hold.
  assign w_spi_tick = (r_spi_cnt == SPI_LAST);
  assign w_spi_done = (r_state == SPI) && w_spi_tick && (r_spi_half == 5'd17);

  // Bridge state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Bridge next state; the reply frame must have started before TX can end.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_rx_valid) w_next = SPI;
      SPI:     if (w_spi_done) w_next = TX;
      TX:      if (!r_tx_start && !w_tx_busy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command capture, SPI mode-0 shifter and reply hand-off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd <= '0; r_resp <= '0; r_leds <= '0;
      r_cs <= 1'b1; r_sck <= 1'b0; r_mosi <= 1'b0; r_tx_start <= 1'b0;
      r_spi_shift <= '0; r_spi_cap <= '0; r_spi_cnt <= '0; r_spi_half <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: if (w_rx_valid) begin
          r_cmd       <= w_rx_data;
          r_leds      <= w_rx_data[3:0];
          r_spi_shift <= w_rx_data;
          r_cs        <= 1'b0;
          r_mosi      <= w_rx_data[7];
          r_spi_cnt   <= '0;
          r_spi_half  <= '0;
        end
        SPI: if (!w_spi_tick) begin
          r_spi_cnt <= r_spi_cnt + 1'b1;
        end else begin
          r_spi_cnt  <= '0;
          r_spi_half <= r_spi_half + 5'd1;
          if (r_spi_half == 5'd17) begin
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_resp     <= r_spi_cap;
            r_tx_start <= 1'b1;
          end else if (!r_spi_half[0] && (r_spi_half != 5'd16)) begin
            r_sck     <= 1'b1;
            r_spi_cap <= {r_spi_cap[6:0], miso_i};
          end else if (r_spi_half[0]) begin
            r_sck <= 1'b0;
            if (r_spi_half != 5'd15) begin
              r_spi_shift <= {r_spi_shift[6:0], 1'b0};
              r_mosi      <= r_spi_shift[6];
            end
          end
        end
        default: begin end
      endcase
    end
  end

  // Nibble for the digit currently being scanned; digit 3 is cmd high nibble.
  always_comb begin
    w_nibble = r_resp[3:0];
    case (r_digit)
      2'd0: w_nibble = r_resp[3:0];
      2'd1: w_nibble = r_resp[7:4];
      2'd2: w_nibble = r_cmd[3:0];
      2'd3: w_nibble = r_cmd[7:4];
      default: w_nibble = r_resp[3:0];
    endcase
  end

  // Display scan: one active-low selector, SCAN_DIV clocks per digit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
      r_seg      <= 8'hFF;
      r_sel      <= 4'hF;
    end else begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_digit    <= r_digit + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_sel <= ~(4'b0001 << r_digit);
      r_seg <= HEX_SEG[w_nibble];
    end
  end

endmodule

// File: tb/tb_freq_meter_top.sv
// Directed bench for freq_meter_top: UART in, SPI flash transfer, UART reply,
// LED and display checks, framing error and reset abort.
module tb_freq_meter_top;
  import freq_meter_pkg::*;

  localparam int BIT = 20;  // 50 MHz / 2.5 Mbaud
  localparam int W   = 8;

  logic       clk_i, rst_i, rx, miso_drv, loop_en;
  logic       tx, flash_CS, sck_o, mosi_o, miso_i;
  wire  [3:0] leds_io;
  logic [7:0] segments;
  logic [3:0] seg_selectors;
  dbg_t       o_dbg;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int sck_cnt   = 0;
  int cs_cnt    = 0;
  int tx_frames = 0;
  logic [7:0] mosi_bits = 8'h00;

  assign miso_i = loop_en ? mosi_o : miso_drv;

  freq_meter_top #(
    .CLK_HZ(50_000_000), .BAUD(2_500_000), .SPI_DIV(4), .SCAN_DIV(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx(rx), .tx(tx), .leds_io(leds_io),
    .flash_CS(flash_CS), .sck_o(sck_o), .mosi_o(mosi_o), .miso_i(miso_i),
    .segments(segments), .seg_selectors(seg_selectors), .o_dbg(o_dbg)
  );

  // clock
  initial begin
    clk_i = 1'b0;
    forever #10 clk_i = ~clk_i;
  end

  // watchdog
  initial begin
    repeat (50000) @(posedge clk_i);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // SPI and chip-select monitors
  always @(posedge sck_o) begin
    sck_cnt   <= sck_cnt + 1;
    mosi_bits <= {mosi_bits[6:0], mosi_o};
  end
  always @(negedge flash_CS) cs_cnt <= cs_cnt + 1;

  // UART TX frame monitor
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (BIT / 2) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk_i);
        b[i] = tx;
      end
      repeat (BIT) @(negedge clk_i);
      got_q.push_back(b);
      tx_frames++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic uart_send(input logic [7:0] d, input logic stop);
    @(negedge clk_i);
    rx = 1'b0;
    repeat (BIT) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk_i);
    end
    rx = stop;
    repeat (BIT) @(negedge clk_i);
    rx = 1'b1;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n;
    n = 0;
    while (tx_frames < target && n < 60 * BIT) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, tx_frames, target);
  endtask

  task automatic check_tx(input string tag);
    logic [7:0] g, e;
    e = exp_q.pop_front();
    if (got_q.size() > 0) g = got_q.pop_front();
    else g = 'x;
    chk(tag, g, e);
  endtask

  task automatic check_digit(input int idx, input logic [7:0] exp_seg, input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << idx);
    n = 0;
    while (seg_selectors !== want && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_sel"}, seg_selectors, want);
    chk(tag, segments, exp_seg);
  endtask

  // directed sequence
  initial begin
    int base_sck, base_cs, base_fr, n;
    rst_i = 1'b1; rx = 1'b0; miso_drv = 1'b0; loop_en = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_tx", tx, 1'b1);
    chk("rst_cs", flash_CS, 1'b1);
    chk("rst_sck", sck_o, 1'b0);
    chk("rst_mosi", mosi_o, 1'b0);
    chk("rst_leds", leds_io, 4'h0);
    chk("rst_seg", segments, 8'hFF);
    chk("rst_sel", seg_selectors, 4'hF);

    // rx held low through and after reset release
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("scan_start_sel", seg_selectors, 4'hE);
    repeat (30 * BIT) @(negedge clk_i);
    chk("low_cs_cnt", cs_cnt, 0);
    chk("low_frames", tx_frames, 0);
    chk("low_cs", flash_CS, 1'b1);
    chk("low_tx", tx, 1'b1);
    chk("low_rx_unarmed", o_dbg.rx, RX_UNARMED);
    for (int d = 0; d < 4; d++) check_digit(d, 8'hC0, "blank");

    // loopback 0xA5
    rx = 1'b1; loop_en = 1'b1;
    repeat (4 * BIT) @(negedge clk_i);
    base_sck = sck_cnt;
    exp_q.push_back(8'hA5);
    uart_send(8'hA5, 1'b1);
    wait_frames(1, "a5_frame");
    chk("a5_sck_pulses", sck_cnt - base_sck, 8);
    chk("a5_mosi", mosi_bits, 8'hA5);
    chk("a5_leds", leds_io, 4'h5);
    check_tx("a5_tx");
    check_digit(3, 8'h88, "a5_d3");
    check_digit(2, 8'h92, "a5_d2");
    check_digit(1, 8'h88, "a5_d1");
    check_digit(0, 8'h92, "a5_d0");

    // miso low, 0x3C, then 0x11 arriving while the reply is being sent
    loop_en = 1'b0; miso_drv = 1'b0;
    base_cs = cs_cnt; base_fr = tx_frames;
    exp_q.push_back(8'h00);
    uart_send(8'h3C, 1'b1);
    uart_send(8'h11, 1'b1);
    wait_frames(base_fr + 1, "3c_frame");
    repeat (20 * BIT) @(negedge clk_i);
    chk("3c_cs_once", cs_cnt - base_cs, 1);
    chk("3c_frames_once", tx_frames - base_fr, 1);
    chk("3c_leds", leds_io, 4'hC);
    check_tx("3c_tx");
    check_digit(3, 8'hB0, "3c_d3");
    check_digit(2, 8'hC6, "3c_d2");
    check_digit(1, 8'hC0, "3c_d1");
    check_digit(0, 8'hC0, "3c_d0");

    // framing error: stop bit 0
    base_cs = cs_cnt; base_fr = tx_frames;
    uart_send(8'h77, 1'b0);
    repeat (10 * BIT) @(negedge clk_i);
    chk("ferr_cs", cs_cnt - base_cs, 0);
    chk("ferr_frames", tx_frames - base_fr, 0);
    chk("ferr_leds", leds_io, 4'hC);

    // valid byte after framing error, reset asserted mid-SPI
    uart_send(8'h5A, 1'b1);
    chk("5a_cs_low", flash_CS, 1'b0);
    chk("5a_leds", leds_io, 4'hA);
    n = 0;
    while (sck_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("5a_sck_high", sck_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("abort_cs", flash_CS, 1'b1);
    chk("abort_sck", sck_o, 1'b0);
    chk("abort_tx", tx, 1'b1);
    chk("abort_leds", leds_io, 4'h0);
    chk("abort_state", o_dbg.bridge, IDLE);
    @(negedge clk_i);
    rst_i = 1'b0;
    base_cs = cs_cnt; base_fr = tx_frames;
    repeat (20 * BIT) @(negedge clk_i);
    chk("post_rst_frames", tx_frames - base_fr, 0);
    chk("post_rst_cs", cs_cnt - base_cs, 0);
    chk("post_rst_state", o_dbg.bridge, IDLE);
    chk("post_rst_tx", tx, 1'b1);
    check_digit(3, 8'hC0, "post_rst_d3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
